pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS32 core.
- It produces the `stall[5:0]` vector, the `flush` strobe and the redirect PC that the inter-stage registers (if_id, id_ex, ex_mem, mem_wb) and the pc register consume.
- It arbitrates stall requests from the id, ex and mem stages against the exception/eret indication from the mem stage.
- It holds a post-flush shadow FSM, stall/flush performance counters and a stall-deadlock watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for every exception type except eret.
- SHADOW_CYCLES, 1, cycles after a flush during which `excepttype_i` is ignored (range 1..15).
- WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (range 2..65535).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallreq_from_id  in  1  id stage requests stall (load-use hazard).
- stallreq_from_ex  in  1  ex stage requests stall (multi-cycle mult/div, madd/msub).
- stallreq_from_mem  in  1  mem stage requests stall (data bus wait).
- excepttype_i  in  32  final exception type from mem stage; 0 = none.
- cp0_epc_i  in  32  current EPC from cp0, already forwarded.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
- flush  out  1  clear all inter-stage registers this cycle.
- new_pc  out  32  PC the pc register loads when `flush` = 1.
- stall_cycles_o  out  32  count of cycles with `stall` != 0, saturating.
- flush_count_o  out  16  count of flushes, wrapping.
- wdog_o  out  1  sticky: stall held for WDOG_LIMIT consecutive cycles.

Behaviour:
- Reset (`rst` = 1, asynchronous) forces these values immediately:
  - `stall` = 0, `flush` = 0, `new_pc` = 0.
  - counters = 0, `wdog_o` = 0.
  - FSM = RUN, shadow counter = 0, run counter = 0.
- `stall`, `flush` and `new_pc` are combinational from the inputs and the FSM state, so they take effect in the same cycle as the request. All other outputs are registered.
- exc_valid = (state == RUN) && (`excepttype_i` != 0).
- Priority, highest first:
  - (a) exc_valid: `flush` = 1, `stall` = 6'b000000. `new_pc` = `cp0_epc_i` if `excepttype_i` == 32'h0000000e (eret), else EXC_VECTOR.
  - (b) `stallreq_from_mem`: `stall` = 6'b011111.
  - (c) `stallreq_from_ex`: `stall` = 6'b001111.
  - (d) `stallreq_from_id`: `stall` = 6'b000111.
  - (e) otherwise `stall` = 0, `flush` = 0, `new_pc` = 0.
- Whenever `flush` = 0, `new_pc` = 0. Exception type codes (1, 8, 0xa, 0xc, 0xd) are not decoded further.
- FSM states are RUN and SHADOW.
  - RUN -> SHADOW on exc_valid; the shadow counter loads SHADOW_CYCLES-1.
  - SHADOW: `excepttype_i` is ignored, so `flush` = 0. Stall requests are arbitrated normally.
  - In SHADOW, the shadow counter decrements each cycle; SHADOW -> RUN when it is 0.
  - With SHADOW_CYCLES = 1, exactly one cycle is spent in SHADOW.
- `flush_count_o` increments by 1 on every cycle with `flush` = 1 and wraps 16'hffff -> 0.
- `stall_cycles_o` increments on every cycle with `stall` != 0 and holds at 32'hffffffff.
- Watchdog:
  - A 16-bit run counter increments each cycle `stall` != 0 and clears to 0 on any cycle with `stall` == 0 or `flush` = 1.
  - When the run counter reaches WDOG_LIMIT-1 while `stall` != 0, `wdog_o` is set on that edge.
  - `wdog_o` is cleared only by `rst`; the run counter saturates at WDOG_LIMIT-1.
- Simultaneous exception and stall requests in RUN: the flush wins and `stall` = 0. The stalled instructions are discarded by the flush.
- Reset asserted mid-SHADOW or mid-stall run returns to RUN with all counters cleared; no partial update occurs.

Decomposition:
- Shared defines header: stall vector constants (STALL_NONE, STALL_ID, STALL_EX, STALL_MEM), EXCTYPE_ERET = 32'h0000000e, the FSM state encodings, the Stop/NoStop levels and the RstEnable level.
- One sub-module: `sat_counter` (parameterised width, saturate-or-wrap select, enable, async active-high reset), instanced for `stall_cycles_o`, `flush_count_o` and the watchdog run counter.

Test Plan:
- `stallreq_from_ex` = 1 for 3 cycles, others 0 -> `stall` = 6'b001111 for exactly those 3 cycles; `stall_cycles_o` 0 -> 3; `flush` = 0 throughout.
- `stallreq_from_id` = 1 and `stallreq_from_mem` = 1 in the same cycle -> `stall` = 6'b011111; after mem drops with id held, the next cycle `stall` = 6'b000111.
- `excepttype_i` = 32'h00000008 with `stallreq_from_ex` = 1 -> `flush` = 1, `stall` = 0, `new_pc` = 32'h00000020, `flush_count_o` = 1. The next cycle with `excepttype_i` still 8 gives `flush` = 0 (SHADOW); the cycle after gives `flush` = 1 again.
- `excepttype_i` = 32'h0000000e, `cp0_epc_i` = 32'hbfc00100 -> `new_pc` = 32'hbfc00100, `flush` = 1 for one cycle.
- WDOG_LIMIT = 8, `stallreq_from_mem` held for 8 cycles -> `wdog_o` rises after the 8th edge and stays 1 after the request drops, until `rst`.
- `rst` pulsed asynchronously (not clock-aligned) while in SHADOW with `stall_cycles_o` = 5 -> all outputs 0 immediately. The first exception after release is honoured (`flush` = 1).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, eret code,
// FSM encodings and control levels.
package pipe_ctrl_pkg;
  localparam logic [5:0]  STALL_NONE   = 6'b000000;
  localparam logic [5:0]  STALL_ID     = 6'b000111;
  localparam logic [5:0]  STALL_EX     = 6'b001111;
  localparam logic [5:0]  STALL_MEM    = 6'b011111;
  localparam logic [31:0] EXCTYPE_ERET = 32'h0000000e;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic        RstEnable    = 1'b1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_e;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with enable, synchronous clear and selectable saturate/wrap.
module sat_counter #(
  parameter int               WIDTH    = 16,
  parameter bit               SATURATE = 1'b1,
  parameter logic [WIDTH-1:0] MAX      = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en && !(SATURATE && (r_cnt == MAX)))
      r_cnt <= r_cnt + WIDTH'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush arbitration, post-flush shadow FSM,
// performance counters and stall-deadlock watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
  parameter int          SHADOW_CYCLES = 1,
  parameter int          WDOG_LIMIT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o,
  output logic        wdog_o
);
  localparam logic [3:0]  SHADOW_LOAD = 4'(SHADOW_CYCLES - 1);
  localparam logic [15:0] RUN_MAX     = 16'(WDOG_LIMIT - 1);

  state_e      r_state;
  logic [3:0]  r_shadow_cnt;
  logic        r_wdog;
  logic        w_exc_valid;
  logic        w_stall_any;
  logic [15:0] w_run_cnt;

  assign w_exc_valid = (r_state == ST_RUN) && (excepttype_i != 32'h0);
  assign w_stall_any = (stall != STALL_NONE);

  // Outputs are gated by rst so they drop immediately, not at the next edge
  always_comb begin
    stall  = STALL_NONE;
    flush  = NoStop;
    new_pc = 32'h0;
    if (rst == RstEnable) begin
      stall  = STALL_NONE;
    end else if (w_exc_valid) begin
      flush  = Stop;
      new_pc = (excepttype_i == EXCTYPE_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else if (stallreq_from_mem) begin
      stall  = STALL_MEM;
    end else if (stallreq_from_ex) begin
      stall  = STALL_EX;
    end else if (stallreq_from_id) begin
      stall  = STALL_ID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= 4'h0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc_valid) begin
            r_state      <= ST_SHADOW;
            r_shadow_cnt <= SHADOW_LOAD;
          end
        end
        ST_SHADOW: begin
          if (r_shadow_cnt == 4'h0)
            r_state <= ST_RUN;
          else
            r_shadow_cnt <= r_shadow_cnt - 4'h1;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(32), .SATURATE(1'b1), .MAX(32'hffffffff)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall_any),
    .i_clr (1'b0),
    .o_cnt (stall_cycles_o)
  );

  sat_counter #(.WIDTH(16), .SATURATE(1'b0), .MAX(16'hffff)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (flush),
    .i_clr (1'b0),
    .o_cnt (flush_count_o)
  );

  // Run counter only measures unbroken stall streaks
  sat_counter #(.WIDTH(16), .SATURATE(1'b1), .MAX(RUN_MAX)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall_any),
    .i_clr (!w_stall_any || flush),
    .o_cnt (w_run_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wdog <= 1'b0;
    else if (w_stall_any && (w_run_cnt == RUN_MAX))
      r_wdog <= 1'b1;
  end

  assign wdog_o = r_wdog;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table through a scoreboard queue,
// plus watchdog and asynchronous-reset sequences.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_r, ex_r, mem_r;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, stall_cycles_o;
  logic [15:0] flush_count_o;
  logic        wdog_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h00000020), .SHADOW_CYCLES(1), .WDOG_LIMIT(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (id_r),
    .stallreq_from_ex  (ex_r),
    .stallreq_from_mem (mem_r),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cycles_o    (stall_cycles_o),
    .flush_count_o     (flush_count_o),
    .wdog_o            (wdog_o)
  );

  typedef struct {
    logic        id, ex, mem;
    logic [31:0] exc, epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc, sc;
    logic [15:0] fc;
    logic        wd;
  } vec_t;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc, sc;
    logic [15:0] fc;
    logic        wd;
  } exp_t;

  vec_t tbl[17];
  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v(logic id, logic ex, logic mem, logic [31:0] x, logic [31:0] p,
                             logic [5:0] st, logic fl, logic [31:0] pc, logic [31:0] sc,
                             logic [15:0] fc, logic wd);
    vec_t r;
    r.id = id; r.ex = ex; r.mem = mem; r.exc = x; r.epc = p;
    r.st = st; r.fl = fl; r.pc = pc; r.sc = sc; r.fc = fc; r.wd = wd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] x, input logic [31:0] p);
    id_r = id; ex_r = ex; mem_r = mem; exc = x; epc = p;
  endtask

  // Leaves the bench at posedge+1 with rst released and inputs idle
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset dominates live requests
    rst = 1'b1;
    drive(0, 0, 1, 32'h8, 32'h0);
    #1;
    check("rst stall",  {26'h0, stall}, 32'h0);
    check("rst flush",  {31'h0, flush}, 32'h0);
    check("rst new_pc", new_pc, 32'h0);
    check("rst sc",     stall_cycles_o, 32'h0);
    check("rst fc",     {16'h0, flush_count_o}, 32'h0);
    check("rst wdog",   {31'h0, wdog_o}, 32'h0);
    do_reset();

    //           id ex mem exc          epc           stall  fl pc            sc  fc wd
    tbl[0]  = v(0, 0, 0, 32'h0,        32'h0,        6'h00, 0, 32'h0,        0, 0, 0);
    tbl[1]  = v(0, 1, 0, 32'h0,        32'h0,        6'h0f, 0, 32'h0,        1, 0, 0);
    tbl[2]  = v(0, 1, 0, 32'h0,        32'h0,        6'h0f, 0, 32'h0,        2, 0, 0);
    tbl[3]  = v(0, 1, 0, 32'h0,        32'h0,        6'h0f, 0, 32'h0,        3, 0, 0);
    tbl[4]  = v(0, 0, 0, 32'h0,        32'h0,        6'h00, 0, 32'h0,        3, 0, 0);
    tbl[5]  = v(1, 0, 1, 32'h0,        32'h0,        6'h1f, 0, 32'h0,        4, 0, 0);
    tbl[6]  = v(1, 0, 0, 32'h0,        32'h0,        6'h07, 0, 32'h0,        5, 0, 0);
    tbl[7]  = v(0, 1, 0, 32'h8,        32'h0,        6'h00, 1, 32'h20,       5, 1, 0);
    tbl[8]  = v(0, 1, 0, 32'h8,        32'h0,        6'h0f, 0, 32'h0,        6, 1, 0);
    tbl[9]  = v(0, 0, 0, 32'h8,        32'h0,        6'h00, 1, 32'h20,       6, 2, 0);
    tbl[10] = v(0, 0, 0, 32'h0,        32'h0,        6'h00, 0, 32'h0,        6, 2, 0);
    tbl[11] = v(0, 0, 0, 32'he,        32'hbfc00100, 6'h00, 1, 32'hbfc00100, 6, 3, 0);
    tbl[12] = v(0, 0, 0, 32'he,        32'hbfc00100, 6'h00, 0, 32'h0,        6, 3, 0);
    tbl[13] = v(0, 0, 0, 32'h0,        32'h0,        6'h00, 0, 32'h0,        6, 3, 0);
    tbl[14] = v(0, 0, 1, 32'h1,        32'h0,        6'h00, 1, 32'h20,       6, 4, 0);
    tbl[15] = v(0, 0, 1, 32'h0,        32'h0,        6'h1f, 0, 32'h0,        7, 4, 0);
    tbl[16] = v(0, 0, 0, 32'h0,        32'h0,        6'h00, 0, 32'h0,        7, 4, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].exc, tbl[i].epc);
      sb.push_back('{tbl[i].st, tbl[i].fl, tbl[i].pc, tbl[i].sc, tbl[i].fc, tbl[i].wd});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d stall", i),  {26'h0, stall}, {26'h0, e.st});
      check($sformatf("v%0d flush", i),  {31'h0, flush}, {31'h0, e.fl});
      check($sformatf("v%0d new_pc", i), new_pc, e.pc);
      @(posedge clk); #1;
      check($sformatf("v%0d sc", i),   stall_cycles_o, e.sc);
      check($sformatf("v%0d fc", i),   {16'h0, flush_count_o}, {16'h0, e.fc});
      check($sformatf("v%0d wdog", i), {31'h0, wdog_o}, {31'h0, e.wd});
    end

    // Watchdog trips on the 8th consecutive stalled edge and stays set
    do_reset();
    drive(0, 0, 1, 32'h0, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("wd edge%0d", k), {31'h0, wdog_o}, (k == 8) ? 32'h1 : 32'h0);
    end
    check("wd sc", stall_cycles_o, 32'd8);
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("wd sticky", {31'h0, wdog_o}, 32'h1);
    check("wd stall idle", {26'h0, stall}, 32'h0);
    do_reset();
    check("wd cleared", {31'h0, wdog_o}, 32'h0);

    // Asynchronous reset in SHADOW with stall_cycles_o = 5
    drive(0, 1, 0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("ar sc5", stall_cycles_o, 32'd5);
    drive(0, 1, 0, 32'h8, 32'h0);
    @(negedge clk);
    check("ar flush", {31'h0, flush}, 32'h1);
    @(posedge clk); #1;
    check("ar shadow flush", {31'h0, flush}, 32'h0);
    check("ar shadow stall", {26'h0, stall}, 32'h0f);
    #2 rst = 1'b1;
    #1;
    check("ar stall",  {26'h0, stall}, 32'h0);
    check("ar flush0", {31'h0, flush}, 32'h0);
    check("ar new_pc", new_pc, 32'h0);
    check("ar sc",     stall_cycles_o, 32'h0);
    check("ar fc",     {16'h0, flush_count_o}, 32'h0);
    check("ar wdog",   {31'h0, wdog_o}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("ar post flush",  {31'h0, flush}, 32'h1);
    check("ar post new_pc", new_pc, 32'h20);
    check("ar post stall",  {26'h0, stall}, 32'h0);
    @(posedge clk); #1;
    check("ar post fc", {16'h0, flush_count_o}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
